// File: rtl/vga_pkg.sv
//==============================================================================
// Module  : vga_pkg
// Brief   : Shared VGA capture types and default frame geometry.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_LOCKED = 2'd2
   } cap_state_t;

   // R+G+B fits in 10 bits (max 765).
   function automatic logic [9:0] rgb_sum(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
      return {2'b00, r} + {2'b00, g} + {2'b00, b};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
//==============================================================================
// Module  : sync_edge_detect
// Brief   : Pixel-strobe-gated falling-edge detector for one sync line.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic pix_en,
   input  logic sync_in,
   output logic fall
);

   logic sync_prev;

   // History idles high so releasing reset with the line high is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_prev <= 1'b1;
      end else if (pix_en) begin
         sync_prev <= sync_in;
      end
   end

   assign fall = pix_en & sync_prev & ~sync_in;

endmodule

`default_nettype wire

// File: rtl/vga_capture.sv
//==============================================================================
// Module  : vga_capture
// Brief   : Locks to incoming VGA timing, captures active pixels, checks frames.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_capture
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        pix_en,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   input  logic        VGA_BLANK_N,
   input  logic [7:0]  VGA_R,
   input  logic [7:0]  VGA_G,
   input  logic [7:0]  VGA_B,
   output logic [9:0]  RxX,
   output logic [9:0]  RxY,
   output logic [23:0] RxRGB,
   output logic        pix_valid,
   output logic        frame_done,
   output logic [15:0] frame_sum,
   output logic        locked,
   output logic [7:0]  err_count
);

   localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
   localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

   cap_state_t  state, state_nx;
   logic [10:0] x_cnt, x_nx;
   logic [10:0] y_cnt, y_nx;
   logic        ovr, ovr_nx;
   logic [15:0] run_sum, sum_nx;
   logic [15:0] fsum_q, fsum_nx;
   logic [7:0]  err_q, err_nx;
   logic        cap, done, fail, clr;
   logic        hs_fall, vs_fall;

   sync_edge_detect u_hs_edge (
      .clk     (Clk),
      .rst     (Reset),
      .pix_en  (pix_en),
      .sync_in (VGA_HS),
      .fall    (hs_fall)
   );

   sync_edge_detect u_vs_edge (
      .clk     (Clk),
      .rst     (Reset),
      .pix_en  (pix_en),
      .sync_in (VGA_VS),
      .fall    (vs_fall)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_SEARCH;
      end else if (pix_en) begin
         state <= state_nx;
      end
   end

   // A sync event in LOCKED closes the line/frame; the same sample is not
   // also captured as a pixel.
   always_comb begin
      state_nx = state;
      x_nx     = x_cnt;
      y_nx     = y_cnt;
      ovr_nx   = ovr;
      sum_nx   = run_sum;
      fsum_nx  = fsum_q;
      err_nx   = err_q;
      cap      = 1'b0;
      done     = 1'b0;
      fail     = 1'b0;
      clr      = 1'b0;

      if (pix_en) begin
         unique case (state)
            ST_SEARCH: begin
               if (vs_fall) begin
                  state_nx = ST_ALIGN;
                  clr      = 1'b1;
               end
            end
            ST_ALIGN: begin
               if (!vs_fall && VGA_BLANK_N) begin
                  state_nx = ST_LOCKED;
                  cap      = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (hs_fall || vs_fall) begin
                  // Line check first so a coincident frame check sees the new y.
                  if (hs_fall && ((x_cnt != 11'd0) || ovr)) begin
                     if ((x_cnt == H_LIM) && !ovr) begin
                        x_nx = 11'd0;
                        y_nx = (y_cnt > V_LIM) ? y_cnt : y_cnt + 11'd1;
                     end else begin
                        fail = 1'b1;
                     end
                  end
                  if (vs_fall && !fail) begin
                     if (y_nx == V_LIM) begin
                        done    = 1'b1;
                        fsum_nx = run_sum;
                        clr     = 1'b1;
                     end else begin
                        fail = 1'b1;
                     end
                  end
               end else if (VGA_BLANK_N) begin
                  if (x_cnt < H_LIM) begin
                     cap = 1'b1;
                  end else begin
                     ovr_nx = 1'b1;
                  end
               end
            end
            default: state_nx = ST_SEARCH;
         endcase
      end

      if (cap) begin
         x_nx   = x_cnt + 11'd1;
         sum_nx = run_sum + {6'd0, rgb_sum(VGA_R, VGA_G, VGA_B)};
      end
      if (fail) begin
         state_nx = ST_SEARCH;
         err_nx   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
         clr      = 1'b1;
      end
      if (clr) begin
         x_nx   = 11'd0;
         y_nx   = 11'd0;
         ovr_nx = 1'b0;
         sum_nx = 16'd0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         x_cnt      <= 11'd0;
         y_cnt      <= 11'd0;
         ovr        <= 1'b0;
         run_sum    <= 16'd0;
         fsum_q     <= 16'd0;
         err_q      <= 8'd0;
         RxX        <= 10'd0;
         RxY        <= 10'd0;
         RxRGB      <= 24'd0;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         pix_valid  <= cap;
         frame_done <= done;
         if (pix_en) begin
            x_cnt   <= x_nx;
            y_cnt   <= y_nx;
            ovr     <= ovr_nx;
            run_sum <= sum_nx;
            fsum_q  <= fsum_nx;
            err_q   <= err_nx;
         end
         if (cap) begin
            RxX   <= x_cnt[9:0];
            RxY   <= y_cnt[9:0];
            RxRGB <= {VGA_R, VGA_G, VGA_B};
         end
      end
   end

   assign locked    = (state == ST_LOCKED);
   assign frame_sum = fsum_q;
   assign err_count = err_q;

endmodule

`default_nettype wire

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, giving the expected active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, giving the expected active lines per frame.
REQ-003 Clk  input  1  system clock (50 MHz); the only clock.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 pix_en  input  1  pixel-rate strobe (one Clk in two for 25 MHz); inputs are sampled only when high.
REQ-006 VGA_HS  input  1  horizontal sync, active low.
REQ-007 VGA_VS  input  1  vertical sync, active low.
REQ-008 VGA_BLANK_N  input  1  high during the active video region.
REQ-009 VGA_R, VGA_G, VGA_B  input  8 each  pixel colour.
REQ-010 RxX, RxY  output  10 each  coordinate of the captured pixel.
REQ-011 RxRGB  output  24  captured {R,G,B}.
REQ-012 pix_valid  output  1  one-Clk pulse marking a valid captured pixel.
REQ-013 frame_done  output  1  one-Clk pulse at the end of a well-formed frame.
REQ-014 frame_sum  output  16  checksum of the last well-formed frame.
REQ-015 locked  output  1  high in state LOCKED.
REQ-016 err_count  output  8  count of framing errors.

Function
REQ-017 All state SHALL advance only on Clk edges with pix_en=1; with pix_en=0, every register SHALL hold and the pulses SHALL be 0.
REQ-018 A sync event SHALL be a 1->0 transition between consecutive pix_en samples of VGA_HS or VGA_VS.
REQ-019 The FSM SHALL have states SEARCH, ALIGN and LOCKED, and SHALL leave reset in SEARCH.
REQ-020 SEARCH -> ALIGN on a VS event; all other inputs are ignored in SEARCH.
REQ-021 ALIGN -> LOCKED on the first sample with VGA_BLANK_N=1; that sample SHALL be captured as x=0, y=0.
REQ-022 In LOCKED, each active sample SHALL be captured at the current x, after which x increments; captures SHALL stop once x reaches H_ACTIVE (no pix_valid), and the overrun SHALL be flagged at the line end.
REQ-023 The captured values SHALL appear on RxX, RxY, RxRGB and pix_valid one Clk after the sampling edge (latency 1).
REQ-024 On an HS event in LOCKED, a line with a nonzero active count SHALL be checked for count == H_ACTIVE; on a pass, y increments and x clears, and a line with zero active pixels SHALL be ignored.
REQ-025 On a VS event in LOCKED, the frame SHALL be checked for y == V_ACTIVE; on a pass, frame_done pulses, frame_sum loads the running sum, the counters and running sum clear, and the FSM stays in LOCKED.
REQ-026 Any failed check SHALL send the FSM to SEARCH, increment err_count (saturating at 255), and leave frame_sum unchanged.
REQ-027 The running sum SHALL be the modulo-2^16 sum of R+G+B over all captured pixels.
REQ-028 When HS and VS events occur on the same sample, the line check SHALL be performed first and the frame check then uses the updated y.
REQ-029 A VS event in ALIGN SHALL keep the FSM in ALIGN.

Reset
REQ-030 While Reset is asserted, the FSM SHALL be in SEARCH and all outputs and internal counters SHALL be 0, including mid-frame.
REQ-031 Sync edge history SHALL reset to 1 (idle), so that the release of Reset never creates a false event.

Structure
REQ-032 Package vga_pkg SHALL hold the state enum and the H_ACTIVE/V_ACTIVE defaults, for sharing with the VGA controller.
REQ-033 One sub-module, sync_edge_detect, SHALL be instantiated per sync line and SHALL provide gated falling-edge detection.

Verification
REQ-034 A drive-a-clean-640x480 frame preceded by VS, with R=G=B=1, SHALL produce frame_done with frame_sum = (921600 mod 65536) = 4096, locked=1 and err_count=0.
REQ-035 Pixel (639,479) = 0x123456 SHALL produce RxX=639, RxY=479, RxRGB=0x123456, with pix_valid one Clk after its sample.
REQ-036 A line of 641 active pixels SHALL produce no pix_valid for the 641st pixel, and the next HS SHALL give SEARCH, err_count=1 and no frame_done.
REQ-037 A frame of 479 lines SHALL cause err_count to increment and frame_sum to hold its prior value.
REQ-038 Asserting Reset at pixel (100,200) SHALL clear all outputs immediately, after which re-lock SHALL occur only after the next VS.
REQ-039 With pix_en tied to 0 during a full frame, there SHALL be no pix_valid and no state change.
